// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and line levels.
// The transmitter is expected to import this same package.
package uart_pkg;

    localparam int   DATA_BITS = 8;
    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the receive pin. Both flops reset to the idle line
// level so that leaving reset never looks like a start bit.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);
    import uart_pkg::*;

    logic meta_q;
    logic sync_q;

    // Metastability chain, synchronous active-low reset to line idle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= LINE_IDLE;
            sync_q <= LINE_IDLE;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Detects the start-bit falling edge, samples each bit at
// its middle, and reports a good byte (rx_done) or a bad stop bit (frame_err)
// with a one-cycle pulse. A line held low after a framing error parks in BREAK
// until it returns high, so a stuck-low line never starts a new frame.
// Build option: define UART_RX_SYNC_EN to put a two-flop synchroniser on rx
// (adds two cycles of latency, needed for an asynchronous pin).
//
// Handshake: rx_done is a one-cycle strobe with no back-pressure; dout is valid
// while rx_done is high and holds its value until the next good byte.
module uart_rx #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] dout,
    output logic       rx_done,
    output logic       frame_err,
    output logic       busy
);
    import uart_pkg::*;

    localparam int HALF  = (CLKS_PER_BIT - 1) / 2;
    localparam int CNT_W = ($clog2(CLKS_PER_BIT + 1) < 1) ? 1 : $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] HALF_C = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(CLKS_PER_BIT - 1);

    logic rx_s;

`ifdef UART_RX_SYNC_EN
    uart_rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (rx),
        .q_o   (rx_s)
    );
`else
    assign rx_s = rx;
`endif

    rx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic                 rx_done_q, rx_done_d;
    logic                 frame_err_q, frame_err_d;

    // State and datapath registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shreg_q     <= '0;
            dout_q      <= '0;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shreg_q     <= shreg_d;
            dout_q      <= dout_d;
            rx_done_q   <= rx_done_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Next state: bit timing, mid-bit sampling and stop-bit decision
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        dout_d      = dout_q;
        rx_done_d   = 1'b0;
        frame_err_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rx_s == START_BIT) begin
                    bit_idx_d = '0;
                    // With one or two clocks per bit the start edge is already mid-bit
                    if (HALF == 0) begin
                        state_d = DATA;
                        cnt_d   = '0;
                    end else begin
                        state_d = START;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            START: begin
                if (cnt_q == HALF_C) begin
                    cnt_d   = '0;
                    // A start bit that is gone by mid-bit was a glitch
                    state_d = (rx_s == START_BIT) ? DATA : IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == LAST_C) begin
                    cnt_d              = '0;
                    shreg_d[bit_idx_q] = rx_s;
                    bit_idx_d          = bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'(DATA_BITS - 1)) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == LAST_C) begin
                    cnt_d = '0;
                    if (rx_s == LINE_IDLE) begin
                        dout_d    = shreg_q;
                        rx_done_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BREAK: begin
                if (rx_s == LINE_IDLE) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs: busy decoded from state, strobes and byte straight from registers
    always_comb begin
        busy      = (state_q != IDLE);
        dout      = dout_q;
        rx_done   = rx_done_q;
        frame_err = frame_err_q;
    end

endmodule
